// File: rtl/data_mem_arb.sv
// data_mem_arb: two-port round-robin arbiter in front of the single read
// port of the constant data memory. The memory output is registered, so each
// granted read returns its word one cycle later. The word is steered to the
// requester that was granted and is also kept in that port's hold register.
//
// Handshake: reqN is held together with addrN until gntN is seen high. The
// request is accepted in that same cycle. rvalidN then pulses for exactly one
// cycle, one cycle after the grant. A port may raise reqN again in the cycle
// after its grant.
module data_mem_arb #(
  parameter int ADDR_NUM   = 128,
  parameter int ADDR_WIDTH = $clog2(ADDR_NUM),
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // ptr_q = 0 favours port 0 when both ports request, 1 favours port 1
  logic                  ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_id_q, resp_id_d;
  logic                  resp_oor_q, resp_oor_d;
  logic [DATA_WIDTH-1:0] hold0_q, hold0_d;
  logic [DATA_WIDTH-1:0] hold1_q, hold1_d;

  logic                  gnt_any;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_oor;
  logic [DATA_WIDTH-1:0] resp_word;

  // Arbitration and memory drive. Grants are gated by rst_n so that reset
  // wins over a request that arrives in the same cycle.
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    gnt0       = rst_n & req0 & (~req1 | ~ptr_q);
    gnt1       = rst_n & req1 & (~req0 |  ptr_q);
    gnt_any    = gnt0 | gnt1;
    sel_addr   = gnt1 ? addr1 : addr0;
    // This can only be true when ADDR_NUM is not a power of two.
    sel_oor    = ({1'b0, sel_addr} >= ADDR_NUM[ADDR_WIDTH:0]);
    mem_rd_en  = gnt_any;
    mem_addr   = gnt_any ? sel_addr : mem_addr_q;
  end

  // Next-state values: pointer rotation, address hold, and response tracking.
  always_comb begin
    ptr_d        = ptr_q;
    mem_addr_d   = mem_addr_q;
    resp_valid_d = gnt_any;
    resp_id_d    = gnt1;
    resp_oor_d   = gnt_any & sel_oor;
    if (gnt_any) begin
      // After a grant, the other port gets priority.
      ptr_d      = gnt0;
      mem_addr_d = sel_addr;
    end
  end

  // Return path: route the registered memory word to the port being served.
  always_comb begin
    resp_word = resp_oor_q ? '0 : mem_rdata;
    rvalid0   = resp_valid_q & ~resp_id_q;
    rvalid1   = resp_valid_q &  resp_id_q;
    hold0_d   = rvalid0 ? resp_word : hold0_q;
    hold1_d   = rvalid1 ? resp_word : hold1_q;
    rdata0    = rvalid0 ? resp_word : hold0_q;
    rdata1    = rvalid1 ? resp_word : hold1_q;
  end

  // State registers. Reset drops any response still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= 1'b0;
      mem_addr_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_oor_q   <= 1'b0;
      hold0_q      <= '0;
      hold1_q      <= '0;
    end else begin
      ptr_q        <= ptr_d;
      mem_addr_q   <= mem_addr_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_oor_q   <= resp_oor_d;
      hold0_q      <= hold0_d;
      hold1_q      <= hold1_d;
    end
  end

endmodule

// File: tb/tb_data_mem_arb.sv
// tb_data_mem_arb: directed test of data_mem_arb. The bench uses a
// registered-output memory model and hand-computed expected values.
module tb_data_mem_arb;
  localparam int AW = 7;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_rd_en;
  logic [DW-1:0] rdata0, rdata1, mem_rdata;
  logic [AW-1:0] mem_addr;

  logic [DW-1:0] mem [0:127];

  int errors = 0;
  int checks = 0;

  data_mem_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .addr0     (addr0),
    .gnt0      (gnt0),
    .rvalid0   (rvalid0),
    .rdata0    (rdata0),
    .req1      (req1),
    .addr1     (addr1),
    .gnt1      (gnt1),
    .rvalid1   (rvalid1),
    .rdata1    (rdata1),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: registered output, holds when not read
  initial mem_rdata = '0;
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic r0, input logic [AW-1:0] a0,
                       input logic r1, input logic [AW-1:0] a1);
    req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = '0;
    mem[1]   = 32'hABCD1234;
    mem[0]   = 32'h00000800;
    mem[121] = 32'hF0000000;
    mem[2]   = 32'd1;
    mem[3]   = 32'd2;
    mem[4]   = 32'd3;
    mem[5]   = 32'd4;
    mem[10]  = 32'hDEAD0010;
    mem[47]  = 32'h00001000;

    // reset state, observed while rst_n is low with requests present
    rst_n = 1'b0;
    drive(1, 5, 1, 6);
    @(negedge clk);
    check("rst_gnt0", {31'd0, gnt0}, 0);
    check("rst_gnt1", {31'd0, gnt1}, 0);
    check("rst_rd_en", {31'd0, mem_rd_en}, 0);
    check("rst_addr", {25'd0, mem_addr}, 0);
    check("rst_rvalid", {30'd0, rvalid1, rvalid0}, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    do_reset();

    // single read of port 0
    drive(1, 1, 0, 0);
    @(negedge clk);
    check("t1_gnt0", {31'd0, gnt0}, 1);
    check("t1_gnt1", {31'd0, gnt1}, 0);
    check("t1_rd_en", {31'd0, mem_rd_en}, 1);
    check("t1_addr", {25'd0, mem_addr}, 1);
    tick();
    drive(0, 0, 0, 0);
    @(negedge clk);
    check("t1_rvalid0", {31'd0, rvalid0}, 1);
    check("t1_rdata0", rdata0, 32'hABCD1234);
    check("t1_rvalid1", {31'd0, rvalid1}, 0);
    tick();
    @(negedge clk);
    check("t1_hold_rvalid0", {31'd0, rvalid0}, 0);
    check("t1_hold_rdata0", rdata0, 32'hABCD1234);
    tick();

    // continuous contention from reset
    do_reset();
    drive(1, 0, 1, 121);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_gnt0", {31'd0, gnt0}, (i % 2 == 0) ? 1 : 0);
      check("t2_gnt1", {31'd0, gnt1}, (i % 2 == 1) ? 1 : 0);
      check("t2_rvalid0", {31'd0, rvalid0}, (i % 2 == 1) ? 1 : 0);
      check("t2_rvalid1", {31'd0, rvalid1}, (i > 0 && i % 2 == 0) ? 1 : 0);
      if (i == 0) check("t2_rdata0_rst", rdata0, 0);
      if (i > 0) check("t2_rdata0", rdata0, 32'h00000800);
      if (i > 1) check("t2_rdata1", rdata1, 32'hF0000000);
      tick();
    end
    drive(0, 0, 0, 0);
    @(negedge clk);
    check("t2_last_rvalid1", {31'd0, rvalid1}, 1);
    check("t2_last_rdata1", rdata1, 32'hF0000000);
    check("t2_idle_gnt", {30'd0, gnt1, gnt0}, 0);
    tick();

    // reset in the middle of a grant cycle
    drive(1, 10, 0, 0);
    @(negedge clk);
    check("t5_gnt0", {31'd0, gnt0}, 1);
    check("t5_addr", {25'd0, mem_addr}, 10);
    #2 rst_n = 1'b0;
    #1;
    check("t5_gnt0_rst", {31'd0, gnt0}, 0);
    check("t5_rd_en_rst", {31'd0, mem_rd_en}, 0);
    check("t5_addr_rst", {25'd0, mem_addr}, 0);
    check("t5_rdata0_rst", rdata0, 0);
    check("t5_rdata1_rst", rdata1, 0);
    tick();
    rst_n = 1'b1;
    drive(1, 0, 1, 121);
    @(negedge clk);
    check("t5_no_rvalid0", {31'd0, rvalid0}, 0);
    check("t5_ptr_gnt0", {31'd0, gnt0}, 1);
    check("t5_ptr_gnt1", {31'd0, gnt1}, 0);
    tick();
    drive(0, 0, 0, 0);
    tick();

    // port 1 burst of four reads
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(0, 0, 1, AW'(2 + i));
      else drive(0, 0, 0, 0);
      @(negedge clk);
      check("t3_gnt1", {31'd0, gnt1}, (i < 4) ? 1 : 0);
      check("t3_rvalid1", {31'd0, rvalid1}, (i > 0) ? 1 : 0);
      if (i > 0) check("t3_rdata1", rdata1, DW'(i));
      check("t3_rdata0", rdata0, 0);
      tick();
    end

    // read of addr 127 on port 1, then idle
    drive(0, 0, 1, 127);
    @(negedge clk);
    check("t4_gnt1", {31'd0, gnt1}, 1);
    tick();
    drive(0, 0, 0, 0);
    @(negedge clk);
    check("t4_rvalid1", {31'd0, rvalid1}, 1);
    check("t4_rdata1", rdata1, 0);
    check("t4_rd_en", {31'd0, mem_rd_en}, 0);
    check("t4_addr", {25'd0, mem_addr}, 127);
    tick();
    @(negedge clk);
    check("t4_idle_rvalid", {30'd0, rvalid1, rvalid0}, 0);
    check("t4_idle_addr", {25'd0, mem_addr}, 127);
    check("t4_idle_rdata1", rdata1, 0);
    tick();

    // port 1 drops its request, then requests again and wins
    do_reset();
    drive(1, 0, 1, 20);
    @(negedge clk);
    check("t6_gnt0", {31'd0, gnt0}, 1);
    check("t6_gnt1", {31'd0, gnt1}, 0);
    tick();
    drive(0, 0, 0, 0);
    @(negedge clk);
    check("t6_drop_gnt", {30'd0, gnt1, gnt0}, 0);
    check("t6_rvalid0", {31'd0, rvalid0}, 1);
    tick();
    drive(1, 0, 1, 47);
    @(negedge clk);
    check("t6_regnt1", {31'd0, gnt1}, 1);
    check("t6_regnt0", {31'd0, gnt0}, 0);
    check("t6_addr", {25'd0, mem_addr}, 47);
    tick();
    drive(0, 0, 0, 0);
    @(negedge clk);
    check("t6_rvalid1", {31'd0, rvalid1}, 1);
    check("t6_rdata1", rdata1, 32'h00001000);
    check("t6_rdata0", rdata0, 32'h00000800);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
